msrv32_ifetch_buf: RTL
======================

Name: msrv32_ifetch_buf

Overview:
Instruction-fetch stage that sits directly downstream of the PC mux (msrv32_pc) and feeds it back. It holds the architectural fetch PC register and drives it to the PC stage's pc_in. It issues instruction-memory requests using a req/ready handshake and buffers returned instructions, tagged with their PC, in a small FIFO. It presents them to decode through a valid/ready handshake and flushes on any redirect.

Parameters:
BOOT_ADDRESS, 32'h0000_0000, fetch PC value after reset; must match the PC stage.
DEPTH, 2, instruction buffer entries; power of 2, minimum 2.
NOP_INSTR, 32'h0000_0013, value driven on instr_out when the buffer is empty (addi x0,x0,0).

Ports:
clk_in  input  1  core clock; all state updates on the rising edge.
rst_in  input  1  synchronous, active-high reset.
next_pc_in  input  32  pc_mux_out from the PC stage; the next fetch address.
redirect_in  input  1  high when pc_src_in != 2'b00 or a branch is taken; flushes the buffer.
pc_out  output  32  current fetch PC; drives the PC stage's pc_in.
imem_req_out  output  1  fetch request valid.
imem_addr_out  output  32  fetch address, always equal to pc_out.
imem_ready_in  input  1  memory accepts the request and returns data in the same cycle.
imem_rdata_in  input  32  instruction word; valid when imem_req_out and imem_ready_in are both high.
instr_valid_out  output  1  buffer head is valid.
instr_out  output  32  head instruction; NOP_INSTR when empty.
instr_pc_out  output  32  head PC; 0 when empty.
instr_misaligned_out  output  1  head entry was fetched from a PC with pc[1:0] != 0.
instr_ready_in  input  1  decode accepts the head entry.
stall_count_out  output  32  see Optional Feature.

Behaviour:
- FSM states: RESET_S, FETCH_S, FLUSH_S.
- rst_in (synchronous, highest priority, including mid-transfer): state=RESET_S, pc_q=BOOT_ADDRESS, buffer count=0, read/write pointers=0. All outputs at reset: imem_req_out=0, instr_valid_out=0, instr_out=NOP_INSTR, instr_pc_out=0, instr_misaligned_out=0, stall_count_out=0.
- RESET_S -> FETCH_S unconditionally on the next cycle. This gives one bubble cycle after reset.
- In FETCH_S: imem_req_out = (count < DEPTH) && (pc_q[1:0] == 2'b00).
- Accept = imem_req_out && imem_ready_in. On accept:
  - push {pc_q, imem_rdata_in, misaligned=0};
  - pc_q <= next_pc_in (the PC stage normally supplies pc_q+4).
- Misaligned PC in FETCH_S with count < DEPTH: no memory request is issued. Push {pc_q, NOP_INSTR, misaligned=1}. pc_q holds until a redirect.
- Pop = instr_valid_out && instr_ready_in. Push and pop in the same cycle leave count unchanged.
- Full (count == DEPTH): no request issued; pc_q holds.
- Empty: instr_valid_out=0.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- redirect_in high in any state other than RESET_S:
  - buffer cleared (count=0, both pointers=0); a pop in the same cycle is ignored;
  - any accept in that cycle is discarded (no push);
  - pc_q <= next_pc_in;
  - state -> FLUSH_S.
- FLUSH_S: imem_req_out=0, then -> FETCH_S. A redirect arriving in FLUSH_S reloads pc_q and stays in FLUSH_S for one more cycle.
- Latency: an instruction accepted in cycle N is visible on instr_valid_out in cycle N+1. There is no combinational path from imem_rdata_in to instr_out.
- All outputs are driven from registers, except imem_req_out, which is a combinational decode of state, count and pc_q.

Optional Feature:
Macro IFETCH_PERF_CNT_EN.
- Defined: stall_count_out is a 32-bit counter that increments every cycle with imem_req_out=1 and imem_ready_in=0. It wraps from 32'hFFFF_FFFF to 0, clears on rst_in, and is not affected by redirect.
- Undefined: stall_count_out is tied to 32'h0 and no counter logic is synthesised.

Test Plan:
- Reset release, then imem_ready_in=1, next_pc_in=pc_out+4, instr_ready_in=1 -> imem_req_out low for 1 cycle; addresses 0x0, 0x4, 0x8 issued on consecutive cycles; instr_pc_out follows 1 cycle later.
- instr_ready_in=0 with the memory always ready -> exactly DEPTH (2) entries accepted; imem_req_out drops; pc_out holds at 0x8; raising ready drains 0x0 then 0x4.
- Buffer holding 2 entries, redirect_in=1 with next_pc_in=0x100 -> next cycle instr_valid_out=0 and pc_out=0x100; one cycle with no request; then a fetch from 0x100.
- next_pc_in=0x102 via redirect -> no memory request; entry with instr_misaligned_out=1, instr_pc_out=0x102, instr_out=0x00000013.
- rst_in asserted mid-stream with the buffer full -> next cycle every output is at its reset value and pc_out=BOOT_ADDRESS.
- With IFETCH_PERF_CNT_EN defined, imem_ready_in=0 for 5 cycles during FETCH_S -> stall_count_out=5. With the macro undefined -> stall_count_out stays 0.

Source files
------------

// File: rtl/msrv32_ifetch_buf.sv
// ---------------------------------------------------------------------------
// msrv32_ifetch_buf
//
// Purpose:
//   Instruction-fetch stage. It holds the architectural fetch PC and feeds it
//   back to the PC mux. It issues instruction-memory requests over a
//   req/ready handshake and buffers the returned words, tagged with their PC,
//   in a small FIFO. The FIFO head goes to decode over valid/ready. Any
//   redirect flushes the FIFO and reloads the fetch PC.
//
// Optional feature:
//   IFETCH_PERF_CNT_EN - when defined, stall_count_out counts the cycles in
//   which a request is pending but memory is not ready. When it is undefined,
//   stall_count_out is tied to zero.
//
// Ports:
//   clk_in               core clock, rising edge
//   rst_in               synchronous active-high reset
//   next_pc_in           next fetch address from the PC mux
//   redirect_in          flush the buffer and load next_pc_in
//   pc_out               current fetch PC (to the PC stage)
//   imem_req_out         fetch request valid (combinational)
//   imem_addr_out        fetch address (== pc_out)
//   imem_ready_in        memory accepts the request; data returns same cycle
//   imem_rdata_in        instruction word returned by memory
//   instr_valid_out      buffer head valid
//   instr_out            head instruction, NOP_INSTR when empty
//   instr_pc_out         head PC, 0 when empty
//   instr_misaligned_out head entry was fetched from a misaligned PC
//   instr_ready_in       decode accepts the head entry
//   stall_count_out      memory-stall cycle counter (see above)
// ---------------------------------------------------------------------------
module msrv32_ifetch_buf #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH        = 2,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] next_pc_in,
  input  logic        redirect_in,
  output logic [31:0] pc_out,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_misaligned_out,
  input  logic        instr_ready_in,
  output logic [31:0] stall_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    FETCH_S = 2'd1,
    FLUSH_S = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;

  // Buffer storage; contents need no reset because count gates visibility.
  logic [31:0]      r_buf_instr [DEPTH];
  logic [31:0]      r_buf_pc    [DEPTH];
  logic             r_buf_mis   [DEPTH];

  logic             w_req;
  logic             w_accept;
  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic             w_has_space;
  logic             w_misaligned;
  logic             w_empty;
  logic [31:0]      w_push_instr;
  logic             w_push_mis;

  assign w_has_space  = (r_count < FULL_CNT);
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_empty      = (r_count == '0);

  // A redirect is ignored in RESET_S; the bubble cycle always completes.
  assign w_flush = redirect_in && (r_state != RESET_S);

  always_comb begin
    w_state_next  = r_state;
    w_req         = 1'b0;
    w_accept      = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_push_instr  = imem_rdata_in;
    w_push_mis    = 1'b0;
    w_pc_next     = r_pc;
    w_count_next  = r_count;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;

    case (r_state)
      RESET_S: begin
        w_state_next = FETCH_S;
      end
      FETCH_S: begin
        w_req    = w_has_space && !w_misaligned;
        w_accept = w_req && imem_ready_in;
        if (w_accept) begin
          w_push    = 1'b1;
          w_pc_next = next_pc_in;
        end else if (w_misaligned && w_has_space) begin
          // A misaligned PC cannot be fetched. Hand decode a tagged NOP
          // instead and hold the PC until a redirect arrives.
          w_push       = 1'b1;
          w_push_instr = NOP_INSTR;
          w_push_mis   = 1'b1;
        end
      end
      FLUSH_S: begin
        w_state_next = FETCH_S;
      end
      default: begin
        w_state_next = RESET_S;
      end
    endcase

    w_pop = !w_empty && instr_ready_in;

    if (w_flush) begin
      // A flush overrides any accept or pop in the same cycle.
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_pc_next     = next_pc_in;
      w_state_next  = FLUSH_S;
      w_count_next  = '0;
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= RESET_S;
      r_pc     <= BOOT_ADDRESS;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_count  <= w_count_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push) begin
      r_buf_instr[r_wr_ptr] <= w_push_instr;
      r_buf_pc[r_wr_ptr]    <= r_pc;
      r_buf_mis[r_wr_ptr]   <= w_push_mis;
    end
  end

  assign pc_out               = r_pc;
  assign imem_addr_out        = r_pc;
  assign imem_req_out         = w_req;
  assign instr_valid_out      = !w_empty;
  assign instr_out            = w_empty ? NOP_INSTR : r_buf_instr[r_rd_ptr];
  assign instr_pc_out         = w_empty ? 32'h0 : r_buf_pc[r_rd_ptr];
  assign instr_misaligned_out = w_empty ? 1'b0 : r_buf_mis[r_rd_ptr];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_stall_count;

  // The counter is not cleared by a redirect; it wraps naturally at 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stall_count <= '0;
    end else if (w_req && !imem_ready_in) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count_out = r_stall_count;
`else
  assign stall_count_out = 32'h0;
`endif

endmodule
